// File: rtl/mpu_motion_capture.sv
// mpu_motion_capture: scales raw MPU X-accel samples to m/s^2 x100 and tracks a quiet baseline.
// It detects movement onset and streams N_SAMPLES decimated samples inside a mov window.
// Latency: raw_valid at cycle t -> mpu_valid at t+2. No backpressure: one raw sample in, at most one emit out.
//
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous active-high reset
//   i_raw_valid      one-cycle strobe, i_raw_accel valid
//   i_raw_accel      signed raw X accel, +/-2g, 16384 LSB/g
//   o_mov            capture window active (CAPTURE and HOLD)
//   o_mpu_valid      one-cycle strobe, o_mpu_valor valid
//   o_mpu_valor      signed scaled sample, m/s^2 x100, held between strobes
//   o_sample_idx     index of the sample on o_mpu_valor within the window
//   o_capture_abort  one-cycle pulse when a capture is abandoned on timeout
//
// Optional feature: define MPU_CAPTURE_TIMEOUT_EN to abort a capture after TIMEOUT_CYC clk cycles
// with no raw sample. Without it, CAPTURE waits indefinitely and o_capture_abort stays 0.

module mpu_motion_capture #(
   parameter int N_SAMPLES   = 30,
   parameter int DECIM       = 2,
   parameter int MOV_THRESH  = 150,
   parameter int TRIG_COUNT  = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int COOLDOWN    = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_raw_valid,
   input  logic [15:0] i_raw_accel,
   output logic        o_mov,
   output logic        o_mpu_valid,
   output logic [31:0] o_mpu_valor,
   output logic [4:0]  o_sample_idx,
   output logic        o_capture_abort
);

   localparam logic [7:0]  TRIG_LAST = 8'(TRIG_COUNT - 1);
   localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 1);
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0]  COOL_LAST = 8'(COOLDOWN - 1);
   localparam logic [4:0]  IDX_LAST  = 5'(N_SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_HOLD     = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_t;

   // ---------------- stage 1: scaling ----------------
   // 16384 LSB/g * 981 / 16384 -> x100 m/s^2. The 27-bit product cannot overflow for 16-bit input.
   logic signed [26:0] w_raw_ext;
   logic signed [26:0] w_prod;
   logic signed [31:0] w_scaled;

   assign w_raw_ext = {{11{i_raw_accel[15]}}, i_raw_accel};
   assign w_prod    = w_raw_ext * 27'sd981;
   assign w_scaled  = {{19{w_prod[26]}}, w_prod[26:14]};   // arithmetic >>> 14 (floor)

   logic signed [31:0] r_s;
   logic               r_s_vld;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_s     <= '0;
         r_s_vld <= 1'b0;
      end else begin
         r_s_vld <= i_raw_valid;
         if (i_raw_valid) begin
            r_s <= w_scaled;
         end
      end
   end

   // ---------------- baseline compare ----------------
   logic signed [31:0] r_base;
   logic               r_base_vld;
   logic signed [32:0] w_diff;
   logic signed [32:0] w_abs;
   logic signed [31:0] w_step;
   logic               w_over;

   // One extra bit so the difference of two full-range values cannot wrap.
   assign w_diff = {r_s[31], r_s} - {r_base[31], r_base};
   assign w_abs  = w_diff[32] ? -w_diff : w_diff;
   assign w_over = (w_abs > $signed(33'(MOV_THRESH)));
   // First-order IIR step of 1/8, floor rounding like the arithmetic shift.
   assign w_step = {{2{w_diff[32]}}, w_diff[32:3]};

   // ---------------- control FSM ----------------
   state_t      r_state;
   logic [7:0]  r_trig_cnt;
   logic [7:0]  r_decim;
   logic [7:0]  r_hold;
   logic [7:0]  r_cool;
   logic [4:0]  w_idx_next;

   assign w_idx_next = o_sample_idx + 5'd1;

`ifdef MPU_CAPTURE_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
   logic [31:0] r_to_cnt;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= ST_IDLE;
         r_base          <= '0;
         r_base_vld      <= 1'b0;
         r_trig_cnt      <= '0;
         r_decim         <= '0;
         r_hold          <= '0;
         r_cool          <= '0;
         o_mov           <= 1'b0;
         o_mpu_valid     <= 1'b0;
         o_mpu_valor     <= '0;
         o_sample_idx    <= '0;
         o_capture_abort <= 1'b0;
`ifdef MPU_CAPTURE_TIMEOUT_EN
         r_to_cnt        <= '0;
`endif
      end else begin
         o_mpu_valid     <= 1'b0;
         o_capture_abort <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (r_s_vld) begin
                  if (!r_base_vld) begin
                     // Very first sample after reset seeds the baseline; no trigger decision.
                     r_base     <= r_s;
                     r_base_vld <= 1'b1;
                     r_trig_cnt <= '0;
                  end else if (!w_over) begin
                     r_base     <= r_base + w_step;
                     r_trig_cnt <= '0;
                  end else if (r_trig_cnt == TRIG_LAST) begin
                     // Triggering sample is emitted immediately as index 0.
                     r_trig_cnt   <= '0;
                     r_decim      <= '0;
                     r_hold       <= '0;
                     o_mov        <= 1'b1;
                     o_mpu_valid  <= 1'b1;
                     o_mpu_valor  <= r_s;
                     o_sample_idx <= '0;
                     r_state      <= (IDX_LAST == 5'd0) ? ST_HOLD : ST_CAPTURE;
`ifdef MPU_CAPTURE_TIMEOUT_EN
                     r_to_cnt     <= '0;
`endif
                  end else begin
                     r_trig_cnt <= r_trig_cnt + 8'd1;
                  end
               end
            end

            ST_CAPTURE: begin
               if (r_s_vld) begin
                  if (r_decim == DEC_LAST) begin
                     r_decim      <= '0;
                     o_mpu_valid  <= 1'b1;
                     o_mpu_valor  <= r_s;
                     o_sample_idx <= w_idx_next;
                     if (w_idx_next == IDX_LAST) begin
                        r_hold  <= '0;
                        r_state <= ST_HOLD;
                     end
                  end else begin
                     r_decim <= r_decim + 8'd1;
                  end
               end
`ifdef MPU_CAPTURE_TIMEOUT_EN
               // Counts cycles since the last raw strobe; a stalled sensor abandons the window.
               if (i_raw_valid) begin
                  r_to_cnt <= '0;
               end else if (r_to_cnt == TO_LAST) begin
                  r_to_cnt        <= '0;
                  o_mov           <= 1'b0;
                  o_capture_abort <= 1'b1;
                  r_cool          <= '0;
                  r_state         <= ST_COOLDOWN;
               end else begin
                  r_to_cnt <= r_to_cnt + 32'd1;
               end
`endif
            end

            ST_HOLD: begin
               // Counts clk cycles, not samples: gives downstream time to latch its result.
               if (r_hold == HOLD_LAST) begin
                  o_mov   <= 1'b0;
                  r_cool  <= '0;
                  r_state <= ST_COOLDOWN;
               end else begin
                  r_hold <= r_hold + 8'd1;
               end
            end

            ST_COOLDOWN: begin
               // Baseline stays frozen so the tail of the gesture cannot drag it.
               if (r_s_vld) begin
                  if (r_cool == COOL_LAST) begin
                     r_trig_cnt <= '0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_cool <= r_cool + 8'd1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
